// File: rtl/ssd_pkg.sv
// ssd_pkg: shared glyph codes, scan state type, cathode decode table and digit-rotation helper
package ssd_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, BLANK} state_e;
  localparam logic [3:0] G_F     = 4'hA;
  localparam logic [3:0] G_L     = 4'hB;
  localparam logic [3:0] G_R     = 4'hC;
  localparam logic [3:0] G_E     = 4'hD;
  localparam logic [3:0] G_DASH  = 4'hE;
  localparam logic [3:0] G_BLANK = 4'hF;
  // Active-low {a,b,c,d,e,f,g,dp}; entry 15 first, entry 0 last.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'hFF, 8'hFD, 8'h61, 8'hF5, 8'hE3, 8'h71, 8'h09, 8'h01,
    8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
  };
  // Next set mask bit above idx, wrapping; returns idx itself when it is the only one set.
  function automatic logic [2:0] next_idx(input logic [7:0] mask, input logic [2:0] idx);
    logic [2:0] r;
    r = idx;
    for (int i = 7; i >= 1; i--)
      if (mask[3'(idx + 3'(i))]) r = 3'(idx + 3'(i));
    return r;
  endfunction
endpackage

// File: rtl/ssd_glyph_decoder.sv
// ssd_glyph_decoder: combinational 4-bit glyph code to active-low 8-bit cathode pattern
//   glyph_i  : glyph code 0x0-0xF
//   seg_n_o  : cathodes {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low
module ssd_glyph_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] glyph_i,
  output logic [7:0] seg_n_o
);
  assign seg_n_o = SEG_TABLE[glyph_i];
endmodule

// File: rtl/ssd_scan_controller.sv
// ssd_scan_controller: multiplexed 8-digit seven-segment scanner with shadow/active glyph banks
//   clk, rst_n           : clock, async active-low reset
//   enable_mask          : digits taking part in the scan
//   wr_valid/ready/idx/glyph : shadow glyph write port
//   commit               : request shadow-to-active copy at the next frame boundary
//   an_n, seg_n          : registered active-low anodes and cathodes
//   frame_done           : one-cycle pulse, high in the first cycle of each new frame
module ssd_scan_controller
  import ssd_pkg::*;
#(
  parameter int DWELL_CYCLES = 262144,
  parameter int BLANK_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] enable_mask,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_idx,
  input  logic [3:0] wr_glyph,
  input  logic       commit,
  output logic [7:0] an_n,
  output logic [7:0] seg_n,
  output logic       frame_done
);
  localparam int DW = DWELL_CYCLES > 1 ? $clog2(DWELL_CYCLES) : 1;
  localparam int BW = BLANK_CYCLES > 1 ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
  state_e        state_q;
  logic [2:0]    idx_q;
  logic [DW-1:0] dwell_q;
  logic [BW-1:0] blank_q;
  logic [3:0]    shadow_q [8];
  logic [3:0]    active_q [8];
  logic          pending_q;
  logic          last_blank;
  logic          boundary;
  logic          copy;
  logic [2:0]    nxt;
  logic [3:0]    glyph;
  logic [7:0]    seg_dec;
  assign nxt        = next_idx(enable_mask, idx_q);
  assign last_blank = state_q == BLANK && blank_q == BLANK_LAST;
  assign boundary   = last_blank && |enable_mask && nxt <= idx_q;
  assign copy       = boundary && pending_q;
  assign wr_ready   = rst_n && !copy;
  // During a copy the digit about to light must already show the freshly copied glyph.
  assign glyph      = copy ? shadow_q[nxt] : active_q[nxt];
  ssd_glyph_decoder u_dec (.glyph_i(glyph), .seg_n_o(seg_dec));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        shadow_q[i] <= G_BLANK;
        active_q[i] <= G_BLANK;
      end
      pending_q <= 1'b0;
    end else begin
      if (wr_valid && wr_ready) shadow_q[wr_idx] <= wr_glyph;
      if (copy) for (int i = 0; i < 8; i++) active_q[i] <= shadow_q[i];
      pending_q <= copy ? commit : pending_q | commit;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= 3'd7;
      dwell_q    <= '0;
      blank_q    <= '0;
      an_n       <= 8'hFF;
      seg_n      <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      case (state_q)
        IDLE: if (|enable_mask) begin
          state_q <= BLANK;
          blank_q <= '0;
        end
        SCAN: if (!enable_mask[idx_q] || dwell_q == DWELL_LAST) begin
          state_q <= BLANK;
          blank_q <= '0;
          an_n    <= 8'hFF;
          seg_n   <= 8'hFF;
        end else dwell_q <= dwell_q + 1'b1;
        BLANK: if (!last_blank) blank_q <= blank_q + 1'b1;
        else if (!(|enable_mask)) state_q <= IDLE;
        else begin
          state_q <= SCAN;
          idx_q   <= nxt;
          dwell_q <= '0;
          an_n    <= ~(8'd1 << nxt);
          seg_n   <= seg_dec;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ssd_scan_controller.sv
// tb_ssd_scan_controller: directed scenarios plus randomized stimulus against a behavioural scan model
module tb_ssd_scan_controller;
  localparam int DW = 4;
  localparam int BL = 2;
  logic       clk = 0;
  logic       rst_n = 0;
  logic [7:0] enable_mask = 0;
  logic       wr_valid = 0;
  logic       wr_ready;
  logic [2:0] wr_idx = 0;
  logic [3:0] wr_glyph = 0;
  logic       commit = 0;
  logic [7:0] an_n, seg_n;
  logic       frame_done;
  always #5 clk = ~clk;
  ssd_scan_controller #(.DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut (
    .clk(clk), .rst_n(rst_n), .enable_mask(enable_mask), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_idx(wr_idx), .wr_glyph(wr_glyph), .commit(commit),
    .an_n(an_n), .seg_n(seg_n), .frame_done(frame_done)
  );
  int n_chk = 0;
  int n_fail = 0;
  // Model: mode 0 = dark/idle, 1 = digit lit, 2 = gap; age = cycles spent in the current mode.
  int         m_mode, m_idx, m_age;
  logic [3:0] m_sh [8];
  logic [3:0] m_ac [8];
  bit         m_pend, m_fd;
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [7:0] seg_of(input logic [3:0] g);
    case (g)
      4'h0: return 8'b00000011;
      4'h1: return 8'b10011111;
      4'h2: return 8'b00100101;
      4'h3: return 8'b00001101;
      4'h4: return 8'b10011001;
      4'h5: return 8'b01001001;
      4'h6: return 8'b01000001;
      4'h7: return 8'b00011111;
      4'h8: return 8'b00000001;
      4'h9: return 8'b00001001;
      4'hA: return 8'b01110001;
      4'hB: return 8'b11100011;
      4'hC: return 8'b11110101;
      4'hD: return 8'b01100001;
      4'hE: return 8'b11111101;
      default: return 8'b11111111;
    endcase
  endfunction
  function automatic int next_on(input logic [7:0] m, input int i);
    for (int k = 1; k <= 8; k++) if (m[(i + k) % 8]) return (i + k) % 8;
    return i;
  endfunction
  function automatic bit m_copy_now();
    return m_mode == 2 && m_age == BL - 1 && enable_mask != 0 &&
           next_on(enable_mask, m_idx) <= m_idx && m_pend;
  endfunction
  task automatic model_reset();
    m_mode = 0; m_idx = 7; m_age = 0; m_pend = 0; m_fd = 0;
    for (int i = 0; i < 8; i++) begin m_sh[i] = 4'hF; m_ac[i] = 4'hF; end
  endtask
  task automatic check_model();
    logic [7:0] ea, es;
    ea = 8'hFF; es = 8'hFF;
    if (m_mode == 1) begin ea[m_idx] = 1'b0; es = seg_of(m_ac[m_idx]); end
    chk("an_n", an_n, ea);
    chk("seg_n", seg_n, es);
    chk("frame_done", {7'b0, frame_done}, {7'b0, m_fd});
    chk("wr_ready", {7'b0, wr_ready}, {7'b0, !m_copy_now()});
  endtask
  task automatic step_model();
    bit cp, fd;
    int n;
    cp = m_copy_now(); fd = 0;
    case (m_mode)
      0: if (enable_mask != 0) begin m_mode = 2; m_age = 0; end
      1: if (!enable_mask[m_idx] || m_age == DW - 1) begin m_mode = 2; m_age = 0; end
         else m_age++;
      default: if (m_age != BL - 1) m_age++;
      else if (enable_mask == 0) m_mode = 0;
      else begin
        n = next_on(enable_mask, m_idx);
        fd = n <= m_idx;
        m_idx = n; m_mode = 1; m_age = 0;
      end
    endcase
    if (cp) for (int i = 0; i < 8; i++) m_ac[i] = m_sh[i];
    if (wr_valid && !cp) m_sh[wr_idx] = wr_glyph;
    m_pend = cp ? commit : (m_pend | commit);
    m_fd = fd;
  endtask
  task automatic sample(); @(negedge clk); check_model(); endtask
  task automatic tick(); step_model(); @(posedge clk); #1; endtask
  task automatic cyc(); sample(); tick(); endtask
  initial begin
    int fds, lows;
    bit found;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_an", an_n, 8'hFF);
    chk("rst_seg", seg_n, 8'hFF);
    chk("rst_fd", {7'b0, frame_done}, 8'h00);
    chk("rst_wr_ready", {7'b0, wr_ready}, 8'h00);
    @(posedge clk); #1;
    rst_n = 1; enable_mask = 8'h1F;
    // Scenario 1: five digits, blank glyphs, frame wraps after digit 4.
    for (int c = 0; c < 36; c++) begin
      sample();
      if (c == 3)  chk("s1_an_c3", an_n, 8'hFE);
      if (c == 6)  chk("s1_an_c6", an_n, 8'hFE);
      if (c == 7)  chk("s1_an_c7", an_n, 8'hFF);
      if (c == 9)  chk("s1_an_c9", an_n, 8'hFD);
      if (c == 21) chk("s1_an_c21", an_n, 8'hF7);
      if (c == 27) chk("s1_an_c27", an_n, 8'hEF);
      if (c == 31) chk("s1_an_c31", an_n, 8'hFF);
      if (c == 33) chk("s1_an_c33", an_n, 8'hFE);
      if (c == 3 || c == 33) chk("s1_fd", {7'b0, frame_done}, 8'h01);
      if (c == 32) chk("s1_fd_c32", {7'b0, frame_done}, 8'h00);
      if (c == 15) chk("s1_seg", seg_n, 8'hFF);
      tick();
    end
    // Scenario 2: shadow writes and a mid-frame commit stay invisible until the next frame.
    wr_valid = 1; wr_idx = 0; wr_glyph = 4'hA; cyc();
    wr_idx = 3; wr_glyph = 4'hD; cyc();
    wr_valid = 0; commit = 1; cyc();
    commit = 0; fds = 0;
    for (int c = 0; c < 120 && fds < 2; c++) begin
      sample();
      if (frame_done) fds++;
      if (an_n != 8'hFF && fds < 2)
        chk("s2_seg", seg_n, fds == 0 ? 8'hFF : an_n == 8'hFE ? 8'h71 : an_n == 8'hF7 ? 8'h61 : 8'hFF);
      tick();
    end
    chk("s2_frames", fds[7:0], 8'd2);
    // Scenario 4: write stream held across a boundary with a commit pending.
    commit = 1; cyc(); commit = 0;
    wr_valid = 1; lows = 0;
    for (int c = 0; c < 40; c++) begin
      wr_idx = 3'(c % 8); wr_glyph = 4'($urandom);
      sample();
      if (!wr_ready) lows++;
      tick();
    end
    wr_valid = 0;
    chk("s4_ready_lows", lows[7:0], 8'd1);
    commit = 1; cyc(); commit = 0;
    repeat (35) cyc();
    // Scenario 3: only digits 0 and 2.
    enable_mask = 8'h05;
    for (int c = 0; c < 40; c++) begin
      sample();
      if (c > 2) chk("s3_an_set", {7'b0, an_n == 8'hFE || an_n == 8'hFB || an_n == 8'hFF}, 8'h01);
      if (c > 2 && frame_done) chk("s3_fd_an", an_n, 8'hFE);
      tick();
    end
    // Scenario 5: mask drops to zero while a digit is lit.
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin sample(); found = an_n != 8'hFF; tick(); end
    chk("s5_found_lit", {7'b0, found}, 8'h01);
    enable_mask = 8'h00;
    cyc();
    for (int c = 0; c < 5; c++) begin sample(); chk("s5_dark", an_n, 8'hFF); tick(); end
    enable_mask = 8'h01; found = 0;
    for (int c = 0; c < 8 && !found; c++) begin sample(); found = an_n == 8'hFE; tick(); end
    chk("s5_resume", {7'b0, found}, 8'h01);
    // Scenario 6: asynchronous reset mid-scan with a commit pending.
    enable_mask = 8'hFF;
    wr_valid = 1; wr_idx = 2; wr_glyph = 4'h5; cyc(); wr_valid = 0;
    commit = 1; cyc(); commit = 0;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin sample(); found = an_n != 8'hFF; tick(); end
    chk("s6_found_lit", {7'b0, found}, 8'h01);
    #1 rst_n = 0;
    #1;
    chk("s6_async_an", an_n, 8'hFF);
    chk("s6_async_seg", seg_n, 8'hFF);
    chk("s6_async_ready", {7'b0, wr_ready}, 8'h00);
    model_reset();
    @(posedge clk); #1 rst_n = 1;
    for (int c = 0; c < 60; c++) begin sample(); chk("s6_no_copy", seg_n, 8'hFF); tick(); end
    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(63) == 0) enable_mask = 8'($urandom);
      wr_valid = $urandom_range(2) == 0;
      wr_idx = 3'($urandom);
      wr_glyph = 4'($urandom);
      commit = $urandom_range(24) == 0;
      cyc();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ssd_scan_controller.md
SSD_SCAN_CONTROLLER -- requirements
Module: ssd_scan_controller

Interface
REQ-001 Parameter DWELL_CYCLES, default 262144: clk cycles one digit is lit (about 381 Hz per digit at 100 MHz).
REQ-002 Parameter BLANK_CYCLES, default 1024: all-anodes-off cycles between digits (anti-ghosting).
REQ-003 clk  input  1: single system clock, all logic on its rising edge.
REQ-004 rst_n  input  1: reset, asynchronous assert, active-low.
REQ-005 enable_mask  input  8: bit i set means digit i takes part in the scan.
REQ-006 wr_valid  input  1: shadow-write request.
REQ-007 wr_ready  output  1: shadow write accepted this cycle when wr_valid&wr_ready.
REQ-008 wr_idx  input  3: digit index to write.
REQ-009 wr_glyph  input  4: glyph code to write.
REQ-010 commit  input  1: one-cycle pulse requesting shadow-to-active copy.
REQ-011 an_n  output  8: anodes, active-low, registered.
REQ-012 seg_n  output  8: cathodes {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low, registered.
REQ-013 frame_done  output  1: one-cycle pulse at each frame boundary.

Function
REQ-014 Glyph codes: 0x0-0x9 are decimal digits; 0xA F=01110001; 0xB L=11100011; 0xC r=11110101; 0xD E=01100001; 0xE dash=11111101; 0xF blank=11111111.
REQ-015 Two 8x4 register files: shadow (written by the port) and active (drives the display).
REQ-016 States: IDLE, SCAN, BLANK.
REQ-017 IDLE: an_n=FF, seg_n=FF. Go to BLANK when enable_mask!=0.
REQ-018 SCAN: an_n has only bit idx low, seg_n=decode(active[idx]). Dwell counter counts 0..DWELL_CYCLES-1, then go to BLANK.
REQ-019 BLANK: an_n=FF, seg_n=FF for BLANK_CYCLES cycles, then go to SCAN on next_idx.
REQ-020 next_idx is the next set bit of enable_mask above idx, wrapping modulo 8. It is sampled in the last BLANK cycle.
REQ-021 If enable_mask==0 in the last BLANK cycle, go to IDLE.
REQ-022 If enable_mask[idx] clears during SCAN, go to BLANK on the next cycle; the dwell is truncated.
REQ-023 Frame boundary: the last BLANK cycle where next_idx<=idx (wrap, or only one digit enabled).
REQ-024 At a frame boundary, pulse frame_done for 1 cycle. If commit_pending=1, copy all 8 shadow entries to active in that cycle and clear commit_pending.
REQ-025 commit sets commit_pending. A commit arriving while pending already set has no further effect.
REQ-026 commit in the same cycle as a copy re-sets commit_pending. The copy uses the pre-commit snapshot.
REQ-027 wr_ready=0 during a copy cycle and while rst_n is low; wr_ready=1 otherwise.
REQ-028 An accepted write updates shadow[wr_idx] on the next edge. A write accepted before the copy cycle is included in that copy.
REQ-029 Commit-to-visible latency: new glyphs appear at the first SCAN after the next frame boundary. There is no tearing within a frame.
REQ-030 Counters are sized $clog2 of their max parameter. Parameters are at least 1.

Reset
REQ-031 rst_n low: state=IDLE, idx=7 (so the first scan starts at the lowest enabled digit), counters=0.
REQ-032 rst_n low: shadow and active all 0xF, commit_pending=0.
REQ-033 rst_n low: an_n=FF, seg_n=FF, frame_done=0, wr_ready=0.
REQ-034 Reset asserted mid-operation blanks the display immediately (asynchronously) and discards any pending commit.

Structure
REQ-035 Shared package ssd_pkg holds glyph code localparams, the state enum typedef and the 16-entry decode constant table.
REQ-036 Sub-module ssd_glyph_decoder (combinational, 4-bit code to 8-bit cathodes) is used once, ahead of the seg_n register.

Verification
REQ-037 Use DWELL=4, BLANK=2 in all scenarios.
REQ-038 Scenario 1: mask=0x1F, no writes. Expect an_n cycling FE,FD,FB,F7,EF, each for 4 cycles with FF for 2 cycles between, seg_n=FF throughout, and frame_done after digit 4.
REQ-039 Scenario 2: write idx0=0xA, idx3=0xD, then commit mid-frame. Expect no change before the boundary. From the next frame, digit0 seg_n=01110001 and digit3 seg_n=01100001.
REQ-040 Scenario 3: mask=0x05. Expect only FE and FB, and frame_done each time the scan wraps from 2 to 0.
REQ-041 Scenario 4: wr_valid held high across a frame boundary with commit pending. Expect wr_ready=0 for exactly that 1 cycle and no lost or duplicated write.
REQ-042 Scenario 5: mask goes to 0 mid-SCAN. Expect BLANK next cycle, then IDLE with an_n=FF. Mask back to 0x01 resumes on digit 0.
REQ-043 Scenario 6: rst_n low mid-SCAN with commit pending. Expect an_n=FF asynchronously, and after release glyphs=0xF with no copy at the next boundary.
